// File: rtl/conv_rd_addr_gen.sv
// Scratchpad read-address generator for the 1-D convolution datapath.
// On start_rd_gen it latches the filter length, stride and IF length, then
// slides a window across the IF scratchpad issuing (IF, filter) read pairs
// under a valid/ready handshake. It reports psum_done per window,
// stride_count_flag per base advance and full_done when every window is done.
// Optional build macro RD_GEN_WIN_CNT_EN adds a win_cnt_o window counter.
module conv_rd_addr_gen #(
  parameter int unsigned FILT_ADDR_LEN = 4,
  parameter int unsigned IF_ADDR_LEN   = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_rd_gen_i,
  input  logic [FILT_ADDR_LEN-1:0] filt_len_i,
  input  logic [IF_ADDR_LEN-1:0]   stride_i,
  input  logic [IF_ADDR_LEN-1:0]   if_len_i,
  input  logic                     pe_ready_i,
  output logic [IF_ADDR_LEN-1:0]   if_rd_addr_o,
  output logic [FILT_ADDR_LEN-1:0] filt_rd_addr_o,
  output logic                     rd_valid_o,
  output logic                     psum_done_o,
  output logic                     stride_count_flag_o,
  output logic                     full_done_o,
  output logic                     busy_o
`ifdef RD_GEN_WIN_CNT_EN
  ,
  output logic [IF_ADDR_LEN-1:0]   win_cnt_o
`endif
);

  // Wide enough that base + stride + filt_len can never wrap.
  localparam int unsigned CmpW =
      ((IF_ADDR_LEN > FILT_ADDR_LEN) ? IF_ADDR_LEN : FILT_ADDR_LEN) + 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StAdvance = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e                   state_q;
  logic [FILT_ADDR_LEN-1:0] filt_len_q;
  logic [IF_ADDR_LEN-1:0]   stride_q;
  logic [IF_ADDR_LEN-1:0]   if_len_q;
  logic [IF_ADDR_LEN-1:0]   base_q;
  logic [FILT_ADDR_LEN-1:0] tap_q;
  logic [IF_ADDR_LEN-1:0]   if_rd_addr_q;
  logic [FILT_ADDR_LEN-1:0] filt_rd_addr_q;
  logic                     rd_valid_q;
  logic                     stride_flag_q;
  logic                     full_done_q;
  logic                     busy_q;

  logic            start_cfg_ok;
  logic            accept;
  logic            last_tap;
  logic [CmpW-1:0] next_end;
  logic            next_fits;

  // Config check uses the raw inputs since they are latched in the same cycle.
  assign start_cfg_ok = (filt_len_i != '0) && (stride_i != '0) &&
                        (CmpW'(filt_len_i) <= CmpW'(if_len_i));

  assign accept    = (state_q == StIssue) && rd_valid_q && pe_ready_i;
  assign last_tap  = (tap_q == (filt_len_q - FILT_ADDR_LEN'(1)));
  assign next_end  = CmpW'(base_q) + CmpW'(stride_q) + CmpW'(filt_len_q);
  assign next_fits = (next_end <= CmpW'(if_len_q));

  // A restart in the same cycle abandons the window, so it gets no psum_done.
  assign psum_done_o = accept && last_tap && !start_rd_gen_i;

  assign if_rd_addr_o        = if_rd_addr_q;
  assign filt_rd_addr_o      = filt_rd_addr_q;
  assign rd_valid_o          = rd_valid_q;
  assign stride_count_flag_o = stride_flag_q;
  assign full_done_o         = full_done_q;
  assign busy_o              = busy_q;

  // Window-walk FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      filt_len_q     <= '0;
      stride_q       <= '0;
      if_len_q       <= '0;
      base_q         <= '0;
      tap_q          <= '0;
      if_rd_addr_q   <= '0;
      filt_rd_addr_q <= '0;
      rd_valid_q     <= 1'b0;
      stride_flag_q  <= 1'b0;
      full_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      stride_flag_q <= 1'b0;
      full_done_q   <= 1'b0;
      if (start_rd_gen_i) begin
        // Restart wins over every other transition.
        filt_len_q     <= filt_len_i;
        stride_q       <= stride_i;
        if_len_q       <= if_len_i;
        base_q         <= '0;
        tap_q          <= '0;
        if_rd_addr_q   <= '0;
        filt_rd_addr_q <= '0;
        busy_q         <= 1'b1;
        if (start_cfg_ok) begin
          state_q    <= StIssue;
          rd_valid_q <= 1'b1;
        end else begin
          state_q     <= StDone;
          rd_valid_q  <= 1'b0;
          full_done_q <= 1'b1;
        end
      end else begin
        case (state_q)
          StIdle: begin
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
          StIssue: begin
            if (accept) begin
              if (last_tap) begin
                tap_q          <= '0;
                rd_valid_q     <= 1'b0;
                if_rd_addr_q   <= '0;
                filt_rd_addr_q <= '0;
                if (next_fits) begin
                  state_q       <= StAdvance;
                  stride_flag_q <= 1'b1;
                end else begin
                  state_q     <= StDone;
                  full_done_q <= 1'b1;
                end
              end else begin
                // if_rd_addr tracks base + tap, so both step together.
                tap_q          <= tap_q + FILT_ADDR_LEN'(1);
                filt_rd_addr_q <= tap_q + FILT_ADDR_LEN'(1);
                if_rd_addr_q   <= if_rd_addr_q + IF_ADDR_LEN'(1);
              end
            end
          end
          StAdvance: begin
            base_q         <= base_q + stride_q;
            if_rd_addr_q   <= base_q + stride_q;
            filt_rd_addr_q <= '0;
            tap_q          <= '0;
            rd_valid_q     <= 1'b1;
            state_q        <= StIssue;
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RD_GEN_WIN_CNT_EN
  logic [IF_ADDR_LEN-1:0] win_cnt_q;

  // Completed-window counter; holds after full_done until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt_q <= '0;
    end else if (start_rd_gen_i) begin
      win_cnt_q <= '0;
    end else if (psum_done_o) begin
      win_cnt_q <= win_cnt_q + IF_ADDR_LEN'(1);
    end
  end

  assign win_cnt_o = win_cnt_q;
`endif

endmodule
